// File: rtl/uart_tx_if.sv
// Host-side handshake and serial-line bundle for uart_tx.
interface uart_tx_if #(
  parameter int DATA_BITS = 7
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 cts;
  logic                 tx;
  logic                 rts;
  logic                 tx_fifo_empty;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 overflow;

  modport master (
    output data_in, data_valid, cts,
    input  tx, rts, tx_fifo_empty, tx_busy, tx_done, overflow
  );

  modport slave (
    input  data_in, data_valid, cts,
    output tx, rts, tx_fifo_empty, tx_busy, tx_done, overflow
  );
endinterface

// File: rtl/uart_tx.sv
// fifo: generic power-of-two queue; write visible to the reader one edge later.
// Backpressure: in_rdy low when full (writes dropped); out_vld low when empty.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         baud_clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign in_rdy  = (count != CW'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld & in_rdy;
  assign pop     = out_rdy & out_vld;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge baud_clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// uart_tx: FIFO-buffered serial transmitter, start/data/parity/stop framing.
// Latency: byte pushed at edge k drives the start bit after edge k+1 (cts high).
// Backpressure: rts low when FIFO full, pushes while full set sticky overflow.
module uart_tx #(
  parameter int DATA_BITS  = 7,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      baud_clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic                   tx_q, tx_nxt;
  logic                   busy_q;
  logic                   done_q, done_nxt;
  logic                   ovf_q;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic                   stop_cnt, stop_cnt_nxt;
  logic                   par, par_nxt;
  logic                   pop;
  logic                   launch_ok;
  logic                   fifo_rdy;
  logic                   fifo_vld;
  logic [DATA_BITS-1:0]   head;

  fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .in_vld   (bus.data_valid),
    .in_dat   (bus.data_in),
    .in_rdy   (fifo_rdy),
    .out_vld  (fifo_vld),
    .out_dat  (head),
    .out_rdy  (pop)
  );

  // cts only matters here, at the moment a new frame would be launched.
  assign launch_ok = fifo_vld & bus.cts;

  always_comb begin
    state_nxt    = state;
    tx_nxt       = tx_q;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par;
    done_nxt     = 1'b0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (launch_ok) begin
          pop       = 1'b1;
          shreg_nxt = head;
          par_nxt   = ^head;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        tx_nxt      = shreg[0];
        shreg_nxt   = shreg >> 1;
        bit_cnt_nxt = '0;
        state_nxt   = DATA;
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          if (PARITY_EN != 0) begin
            state_nxt = PARITY;
            tx_nxt    = par;
          end else begin
            state_nxt    = STOP;
            tx_nxt       = 1'b1;
            stop_cnt_nxt = 1'b0;
          end
        end else begin
          tx_nxt      = shreg[0];
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        state_nxt    = STOP;
        tx_nxt       = 1'b1;
        stop_cnt_nxt = 1'b0;
      end
      STOP: begin
        if (stop_cnt == STOP_LAST) begin
          done_nxt = 1'b1;
          if (launch_ok) begin
            pop       = 1'b1;
            shreg_nxt = head;
            par_nxt   = ^head;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          stop_cnt_nxt = stop_cnt + 1'b1;
          tx_nxt       = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= (state_nxt != IDLE);
      done_q   <= done_nxt;
      ovf_q    <= ovf_q | (bus.data_valid & ~fifo_rdy);
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par      <= par_nxt;
    end
  end

  assign bus.tx            = tx_q;
  assign bus.tx_busy       = busy_q;
  assign bus.tx_done       = done_q;
  assign bus.overflow      = ovf_q;
  assign bus.rts           = fifo_rdy;
  assign bus.tx_fifo_empty = ~fifo_vld;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench: default config (u0) plus parity/two-stop config (u1).
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   dc0 = 0;
  int   dc1 = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(7)) b0 ();
  uart_tx_if #(.DATA_BITS(7)) b1 ();

  uart_tx #(.DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .baud_clk (clk),
    .rst_n    (rst_n),
    .bus      (b0)
  );

  uart_tx #(.DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .baud_clk (clk),
    .rst_n    (rst_n),
    .bus      (b1)
  );

  always @(negedge clk) begin
    if (b0.tx_done === 1'b1) dc0++;
    if (b1.tx_done === 1'b1) dc1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input string tag, input logic [15:0] pat, input int lo, input int hi,
                       input int which);
    for (int i = lo; i <= hi; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i), (which != 0) ? b1.tx : b0.tx, pat[i]);
    end
  endtask

  // Frame with one stop bit, no parity: start 0, 7 data bits LSB first, stop 1.
  function automatic logic [15:0] fpat(input logic [6:0] b);
    return {7'b0, 1'b1, b, 1'b0};
  endfunction

  initial begin
    logic [6:0] qb [5];
    int d0;
    int lows;
    qb = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};

    rst_n = 1'b0;
    b0.data_in = '0; b0.data_valid = 1'b0; b0.cts = 1'b1;
    b1.data_in = '0; b1.data_valid = 1'b0; b1.cts = 1'b1;
    repeat (2) tick();
    chk("rst_tx",      b0.tx, 1);
    chk("rst_rts",     b0.rts, 1);
    chk("rst_empty",   b0.tx_fifo_empty, 1);
    chk("rst_busy",    b0.tx_busy, 0);
    chk("rst_done",    b0.tx_done, 0);
    chk("rst_ovf",     b0.overflow, 0);
    chk("rst_tx_u1",   b1.tx, 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_tx", b0.tx, 1);

    // Single 0x55 frame, default configuration
    d0 = dc0;
    b0.data_valid = 1'b1; b0.data_in = 7'h55;
    tick();
    b0.data_valid = 1'b0; b0.data_in = 7'h7F;
    chk("t1_tx_push_edge", b0.tx, 1);
    chk("t1_empty",        b0.tx_fifo_empty, 0);
    frame("t1", 16'h01AA, 0, 8, 0);
    chk("t1_busy_stop", b0.tx_busy, 1);
    tick();
    chk("t1_done",      b0.tx_done, 1);
    chk("t1_tx_idle",   b0.tx, 1);
    chk("t1_busy_idle", b0.tx_busy, 0);
    tick();
    chk("t1_done_low",  b0.tx_done, 0);
    chk("t1_done_cnt",  dc0 - d0, 1);

    // 0x07 with even parity and two stop bits
    b1.data_valid = 1'b1; b1.data_in = 7'h07;
    tick();
    b1.data_valid = 1'b0;
    chk("t2_tx_push_edge", b1.tx, 1);
    frame("t2", 16'h070E, 0, 10, 1);
    tick();
    chk("t2_done",    b1.tx_done, 1);
    chk("t2_tx_idle", b1.tx, 1);
    tick();
    chk("t2_done_cnt", dc1, 1);

    // cts low: fill FIFO, overflow on fifth push, then drain back-to-back
    b0.cts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b0.data_valid = 1'b1; b0.data_in = qb[i];
      tick();
      if (i == 3) chk("t3_rts_full", b0.rts, 0);
    end
    b0.data_valid = 1'b0;
    chk("t3_ovf",  b0.overflow, 1);
    chk("t3_busy", b0.tx_busy, 0);
    repeat (3) tick();
    chk("t3_tx_held", b0.tx, 1);
    d0 = dc0;
    b0.cts = 1'b1;
    for (int f = 0; f < 4; f++) frame($sformatf("t3_f%0d", f), fpat(qb[f]), 0, 8, 0);
    tick();
    chk("t3_last_done", b0.tx_done, 1);
    tick();
    chk("t3_done_cnt",  dc0 - d0, 4);
    chk("t3_empty",     b0.tx_fifo_empty, 1);
    chk("t3_rts_back",  b0.rts, 1);
    chk("t3_ovf_stick", b0.overflow, 1);
    repeat (2) tick();
    chk("t3_no_5th", b0.tx, 1);

    // 0x2A with cts dropped during data bit 3; 0x15 pushed on the launch edge
    b0.data_valid = 1'b1; b0.data_in = 7'h2A;
    tick();
    b0.data_in = 7'h15;
    tick();
    b0.data_valid = 1'b0;
    chk("t4_start",       b0.tx, 0);
    chk("t4_count_kept",  b0.tx_fifo_empty, 0);
    frame("t4a", fpat(7'h2A), 1, 4, 0);
    b0.cts = 1'b0;
    frame("t4a", fpat(7'h2A), 5, 8, 0);
    tick();
    chk("t4_done",    b0.tx_done, 1);
    chk("t4_tx_hold", b0.tx, 1);
    repeat (4) tick();
    chk("t4_held_tx",    b0.tx, 1);
    chk("t4_held_busy",  b0.tx_busy, 0);
    chk("t4_held_queue", b0.tx_fifo_empty, 0);
    b0.cts = 1'b1;
    frame("t4b", fpat(7'h15), 0, 8, 0);
    tick();
    chk("t4b_done", b0.tx_done, 1);
    tick();
    chk("t4b_empty", b0.tx_fifo_empty, 1);

    // Reset mid-frame with two bytes still queued
    b0.data_valid = 1'b1; b0.data_in = 7'h01;
    tick();
    b0.data_in = 7'h02;
    tick();
    b0.data_in = 7'h03;
    tick();
    b0.data_valid = 1'b0;
    tick();
    chk("t5_in_frame", b0.tx_busy, 1);
    d0 = dc0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tx",    b0.tx, 1);
    chk("t5_async_empty", b0.tx_fifo_empty, 1);
    chk("t5_async_busy",  b0.tx_busy, 0);
    chk("t5_async_rts",   b0.rts, 1);
    chk("t5_async_ovf",   b0.overflow, 0);
    tick();
    rst_n = 1'b1;
    lows = 0;
    repeat (20) begin
      tick();
      if (b0.tx !== 1'b1) lows++;
    end
    chk("t5_no_frames", lows, 0);
    chk("t5_no_done",   dc0 - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_BITS, default 7, payload width per frame.
REQ-002 Parameter: PARITY_EN, default 0, 1 = append even-parity bit after data.
REQ-003 Parameter: STOP_BITS, default 1, legal values 1 or 2.
REQ-004 Parameter: FIFO_DEPTH, default 4, power of two, minimum 2.
REQ-005 baud_clk  in  1  sole clock, one bit period per rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 data_in  in  DATA_BITS  byte to transmit.
REQ-008 data_valid  in  1  write strobe, data_in pushed on rising edge when accepted.
REQ-009 cts  in  1  clear-to-send, high = far end may receive.
REQ-010 tx  out  1  serial line, idle high.
REQ-011 rts  out  1  high when FIFO not full (may accept data).
REQ-012 tx_fifo_empty  out  1  FIFO count == 0.
REQ-013 tx_busy  out  1  state != IDLE.
REQ-014 tx_done  out  1  one-cycle pulse per completed frame.
REQ-015 overflow  out  1  sticky, push attempted while full.

Function
REQ-016 FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-017 Frame on tx: start 0, DATA_BITS data LSB first, parity if PARITY_EN, STOP_BITS ones; each bit exactly one baud_clk cycle.
REQ-018 Push: data_valid=1 and count<FIFO_DEPTH at edge -> entry written, count+1.
REQ-019 Push while full (count==FIFO_DEPTH before edge) -> data dropped, overflow<=1, even if pop on same edge.
REQ-020 Simultaneous accepted push and pop -> count unchanged, order preserved.
REQ-021 Read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-022 Launch: at edge with state IDLE, count>0, cts=1 -> pop head into shift register, state<=START, tx<=0.
REQ-023 Latency: push into empty FIFO at edge k with cts=1 -> tx=0 after edge k+1.
REQ-024 cts sampled only at launch decision; cts falling mid-frame does not stop, stretch or alter frame.
REQ-025 Parity bit = XOR of all DATA_BITS payload bits (even parity).
REQ-026 Last stop bit ends: if count>0 and cts=1 -> next START immediately (zero idle cycles); else IDLE, tx=1.
REQ-027 tx_done=1 for exactly the cycle after the edge ending the last stop bit, including back-to-back frames.
REQ-028 Bit counter width ceil(log2(DATA_BITS+1)); DATA->PARITY/STOP after DATA_BITS cycles.
REQ-029 rts = ~full, tx_fifo_empty = (count==0), both updated from registered count.
REQ-030 data_in ignored when data_valid=0; tx never X after reset.

Reset
REQ-031 rst_n=0 asynchronously forces: state IDLE, tx=1, count 0, pointers 0, tx_busy 0, tx_done 0, overflow 0, rts 1, tx_fifo_empty 1.
REQ-032 Reset mid-frame aborts frame immediately (tx=1), discards FIFO contents; no tx_done.
REQ-033 After rst_n rises, first launch no earlier than first edge with count>0 and cts=1.
REQ-034 FIFO storage contents need not be reset.

Verification
REQ-035 Defaults, cts=1, push 0x55 -> tx 0,1,0,1,0,1,0,1,1 over 9 cycles starting one cycle after push, tx_done once, then tx=1.
REQ-036 PARITY_EN=1, STOP_BITS=2, push 0x07 -> tx 0,1,1,1,0,0,0,0,1,1,1 (parity 1), 11 cycles.
REQ-037 cts=0, push 5 bytes -> 4 accepted, rts=0, overflow=1, tx stays 1; cts=1 -> 4 frames back-to-back, no idle gaps, 4 tx_done pulses.
REQ-038 cts dropped during data bit 3 of 0x2A -> frame completes unchanged; next queued frame held until cts=1.
REQ-039 rst_n low during DATA with 2 queued bytes -> tx=1 asynchronously, tx_fifo_empty=1, no further frames.
REQ-040 Push and launch-pop on same edge with count=1 -> count stays 1, bytes sent in push order.
